mpram_tagged: RTL
=================

Name: mpram_tagged

Overview:
- Parametrised multi-port label RAM for the garbled-circuit datapath: NW write ports, NR read ports, K-bit wire labels, per-entry valid status.
- Replaces the flat flag-vector approach with per-entry epoch tags, so clearing all valid status normally takes one cycle.
- Adds registered reads, write-conflict arbitration and optional write-to-read forwarding.
- Sits between the gate-evaluation pipeline and the label store.

Parameters:
- S, 10: address width; depth is 2**S entries.
- K, 128: data (label) width.
- NW, 2: number of write ports.
- NR, 2: number of read ports.
- E, 4: epoch tag width; valid epochs are 1..2**E-1.
- BYPASS, 1: 1 = a read returns same-cycle write data; 0 = a read returns the pre-write contents.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  one-cycle pulse; invalidates all entries.
- busy  out  1  high during a sweep; ports are blocked.
- wr_en  in  NW  per-port write enable.
- wr_addr  in  NW*S  port i occupies bits [i*S +: S].
- wr_data  in  NW*K  port i occupies bits [i*K +: K].
- wr_conflict  out  1  registered; pulses when two or more enabled write ports target the same address.
- rd_en  in  NR  per-port read enable.
- rd_addr  in  NR*S  port j occupies bits [j*S +: S].
- rd_valid  out  NR  registered; rd_en delayed by one cycle.
- rd_hit  out  NR  registered; the entry was written in the current epoch.
- rd_data  out  NR*K  registered read data.

Behaviour:
- Storage:
  - data[2**S] of K bits.
  - tag[2**S] of E bits.
  - cur_epoch register, E bits.
  - An entry is valid iff tag == cur_epoch. Tag 0 is never valid.
- Reset (async):
  - cur_epoch=1, state=SWEEP, sweep_ptr=0, busy=1.
  - rd_valid=0, rd_hit=0, rd_data=0, wr_conflict=0.
  - Data contents are undefined after reset.
- State machine:
  - RUN:
    - clr with cur_epoch < 2**E-1: cur_epoch++, stay in RUN. All entries become invalid on the next cycle.
    - clr with cur_epoch == 2**E-1: go to SWEEP with sweep_ptr=0.
  - SWEEP:
    - Each cycle: tag[sweep_ptr]=0, then sweep_ptr++.
    - When sweep_ptr == 2**S-1 has been cleared: cur_epoch=1, return to RUN.
    - A sweep takes exactly 2**S cycles. busy is high for every SWEEP cycle and low on the first RUN cycle.
- While busy:
  - wr_en is ignored.
  - rd_en still produces rd_valid=1 one cycle later, with rd_hit=0 and rd_data=0.
  - clr is ignored.
- Write, RUN state:
  - At the clock edge: data[addr]=wr_data and tag[addr]=cur_epoch for every enabled port.
  - Same-address conflict: the highest port index wins, and wr_conflict=1 on the following cycle.
  - A write in the same cycle as clr is tagged with the old epoch, so it is invalid after the clear (clr wins).
  - A write in the same cycle as a clr that starts a SWEEP is discarded.
- Read:
  - 1-cycle latency. rd_en/rd_addr sampled at edge t; rd_valid/rd_hit/rd_data appear after edge t, valid during cycle t+1.
  - rd_en=0: rd_valid=0; rd_data and rd_hit hold their previous values.
  - rd_hit=0 forces rd_data=0.
  - Read in the same cycle as clr: sees the pre-clear state.
  - Read in the same cycle as a write to the same address:
    - BYPASS=1: returns the winning write's data with rd_hit=1.
    - BYPASS=0: returns the old data and old hit status.
  - Reads on different ports are independent; any ports may read the same address.
- Epoch wrap: 2**E-2 clears cost one cycle each; the next clr costs a 2**S-cycle sweep.

Decomposition:
- Package mpram_pkg:
  - Epoch width default and epoch constants: EPOCH_INVALID=0, EPOCH_FIRST=1.
  - State enum: RUN, SWEEP.
- Sub-module mpram_wr_arbiter (combinational):
  - Per-address winner select across NW ports.
  - Conflict detect.
  - Produces effective write enables and the forwarding data used for bypass.

Test Plan (S=4, K=8, NW=2, NR=2, E=2):
- Reset: assert rst mid-operation, then release -> busy=1 for exactly 16 cycles, then 0. A read of addr 3 during busy gives rd_valid=1, rd_hit=0, rd_data=0.
- Basic: write port0 addr 5 = 0xA5; read port1 addr 5 next cycle -> rd_valid=1, rd_hit=1, rd_data=0xA5 one cycle after rd_en. Read addr 6 -> rd_hit=0, rd_data=0.
- Conflict: both ports write addr 2 (port0 0x11, port1 0x22) -> wr_conflict=1 next cycle; a subsequent read returns 0x22.
- Bypass: same-cycle write addr 7 = 0x3C and read addr 7.
  - BYPASS=1 -> 0x3C, hit=1.
  - BYPASS=0 -> hit=0, data=0.
- Clear: write addr 1, clr, then read addr 1 -> hit=0, busy stays 0. Repeat for clr #2 -> busy stays 0. clr #3 (epoch 3 -> wrap) -> busy=1 for 16 cycles; then write addr 1 = 0x55 and read -> hit=1, data=0x55.
- clr with same-cycle write to addr 4, plus a same-cycle read of a previously written addr 9 -> read returns old addr 9 data with hit=1; a later read of addr 4 gives hit=0.

Source files
------------

// File: rtl/mpram_pkg.sv
// rtl/mpram_pkg.sv - shared epoch constants and state encoding for the tagged label RAM
package mpram_pkg;

    localparam int EPOCH_W_DEFAULT = 4;
    localparam int EPOCH_INVALID   = 0;
    localparam int EPOCH_FIRST     = 1;

    typedef enum logic {
        RUN   = 1'b0,
        SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/mpram_wr_arbiter.sv
// rtl/mpram_wr_arbiter.sv - same-address write winner select, conflict detect and read forwarding
module mpram_wr_arbiter #(
    parameter int S  = 10,
    parameter int K  = 128,
    parameter int NW = 2,
    parameter int NR = 2
) (
    input  logic [NW-1:0]   wr_en,
    input  logic [NW*S-1:0] wr_addr,
    input  logic [NW*K-1:0] wr_data,
    input  logic [NR*S-1:0] rd_addr,
    output logic [NW-1:0]   we_eff,
    output logic            conflict,
    output logic [NR-1:0]   fwd_hit,
    output logic [NR*K-1:0] fwd_data
);

    // A lower port loses whenever any higher port targets the same address.
    always_comb begin
        we_eff   = wr_en;
        conflict = 1'b0;
        for (int i = 0; i < NW; i++) begin
            for (int j = i + 1; j < NW; j++) begin
                if (wr_en[i] && wr_en[j] && (wr_addr[i*S +: S] == wr_addr[j*S +: S])) begin
                    we_eff[i] = 1'b0;
                    conflict  = 1'b1;
                end
            end
        end
    end

    // Ascending scan so the highest matching port's data is what gets forwarded.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        for (int j = 0; j < NR; j++) begin
            for (int i = 0; i < NW; i++) begin
                if (wr_en[i] && (wr_addr[i*S +: S] == rd_addr[j*S +: S])) begin
                    fwd_hit[j]         = 1'b1;
                    fwd_data[j*K +: K] = wr_data[i*K +: K];
                end
            end
        end
    end

endmodule

// File: rtl/mpram_tagged.sv
// rtl/mpram_tagged.sv - multi-port label RAM with epoch-tagged validity and registered reads
module mpram_tagged
    import mpram_pkg::*;
#(
    parameter int S      = 10,
    parameter int K      = 128,
    parameter int NW     = 2,
    parameter int NR     = 2,
    parameter int E      = EPOCH_W_DEFAULT,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    output logic            busy,
    input  logic [NW-1:0]   wr_en,
    input  logic [NW*S-1:0] wr_addr,
    input  logic [NW*K-1:0] wr_data,
    output logic            wr_conflict,
    input  logic [NR-1:0]   rd_en,
    input  logic [NR*S-1:0] rd_addr,
    output logic [NR-1:0]   rd_valid,
    output logic [NR-1:0]   rd_hit,
    output logic [NR*K-1:0] rd_data
);

    localparam int             DEPTH     = 1 << S;
    localparam logic [E-1:0]   EPOCH_MAX = {E{1'b1}};
    localparam logic [E-1:0]   EP_FIRST  = E'(EPOCH_FIRST);
    localparam logic [E-1:0]   EP_INVAL  = E'(EPOCH_INVALID);
    localparam logic [S-1:0]   PTR_LAST  = S'(DEPTH - 1);

    logic [K-1:0] data_q [DEPTH];
    logic [E-1:0] tag_q  [DEPTH];

    state_t          state_q, state_d;
    logic [E-1:0]    epoch_q, epoch_d;
    logic [S-1:0]    sweep_ptr_q, sweep_ptr_d;
    logic            wr_conflict_q, wr_conflict_d;
    logic [NR-1:0]   rd_valid_q, rd_valid_d;
    logic [NR-1:0]   rd_hit_q, rd_hit_d;
    logic [NR*K-1:0] rd_data_q, rd_data_d;

    logic            busy_int;
    logic            wrap_clr;
    logic            wr_accept;
    logic [NW-1:0]   wr_en_gated;
    logic [NW-1:0]   we_eff;
    logic            conflict;
    logic [NR-1:0]   fwd_hit;
    logic [NR*K-1:0] fwd_data;

    assign busy_int    = (state_q == SWEEP);
    assign wrap_clr    = !busy_int && clr && (epoch_q == EPOCH_MAX);
    // A write racing a wrapping clear is dropped rather than tagged into a swept table.
    assign wr_accept   = !busy_int && !wrap_clr;
    assign wr_en_gated = wr_en & {NW{wr_accept}};

    mpram_wr_arbiter #(
        .S  (S),
        .K  (K),
        .NW (NW),
        .NR (NR)
    ) u_wr_arbiter (
        .wr_en    (wr_en_gated),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .we_eff   (we_eff),
        .conflict (conflict),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

    always_comb begin
        state_d     = state_q;
        epoch_d     = epoch_q;
        sweep_ptr_d = sweep_ptr_q;
        case (state_q)
            RUN: begin
                if (clr) begin
                    if (epoch_q == EPOCH_MAX) begin
                        state_d     = SWEEP;
                        sweep_ptr_d = '0;
                    end else begin
                        epoch_d = epoch_q + 1'b1;
                    end
                end
            end
            SWEEP: begin
                sweep_ptr_d = sweep_ptr_q + 1'b1;
                if (sweep_ptr_q == PTR_LAST) begin
                    state_d = RUN;
                    epoch_d = EP_FIRST;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wr_conflict_d = conflict;
        rd_valid_d    = rd_en;
        rd_hit_d      = rd_hit_q;
        rd_data_d     = rd_data_q;
        for (int j = 0; j < NR; j++) begin
            if (rd_en[j]) begin
                if (busy_int) begin
                    rd_hit_d[j]         = 1'b0;
                    rd_data_d[j*K +: K] = '0;
                end else if ((BYPASS != 0) && fwd_hit[j]) begin
                    rd_hit_d[j]         = 1'b1;
                    rd_data_d[j*K +: K] = fwd_data[j*K +: K];
                end else if (tag_q[rd_addr[j*S +: S]] == epoch_q) begin
                    rd_hit_d[j]         = 1'b1;
                    rd_data_d[j*K +: K] = data_q[rd_addr[j*S +: S]];
                end else begin
                    rd_hit_d[j]         = 1'b0;
                    rd_data_d[j*K +: K] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SWEEP;
            epoch_q       <= EP_FIRST;
            sweep_ptr_q   <= '0;
            wr_conflict_q <= 1'b0;
            rd_valid_q    <= '0;
            rd_hit_q      <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            epoch_q       <= epoch_d;
            sweep_ptr_q   <= sweep_ptr_d;
            wr_conflict_q <= wr_conflict_d;
            rd_valid_q    <= rd_valid_d;
            rd_hit_q      <= rd_hit_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Storage arrays carry no reset; the post-reset sweep zeroes every tag.
    always_ff @(posedge clk) begin
        if (state_q == SWEEP) begin
            tag_q[sweep_ptr_q] <= EP_INVAL;
        end
        for (int i = 0; i < NW; i++) begin
            if (we_eff[i]) begin
                data_q[wr_addr[i*S +: S]] <= wr_data[i*K +: K];
                tag_q[wr_addr[i*S +: S]]  <= epoch_q;
            end
        end
    end

    assign busy        = busy_int;
    assign wr_conflict = wr_conflict_q;
    assign rd_valid    = rd_valid_q;
    assign rd_hit      = rd_hit_q;
    assign rd_data     = rd_data_q;

endmodule
